writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 74 +++++++
 rtl/writeback_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared defaults and commit-source state encoding for the write-back arbiter
package wb_pkg;

    localparam int DEF_DATA_W     = 9;
    localparam int DEF_ADDR_W     = 3;
    localparam int DEF_FIFO_DEPTH = 2;

    // Last commit source; drives the MemtoReg select
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB_ALU = 2'd1,
        WB_MEM = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small circular buffer holding ALU write-back requests
module wb_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Overflow/underflow requests are ignored rather than corrupting state
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance wraps at DEPTH so non-power-of-two depths work
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers; reset empties the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges load responses and buffered ALU results into one register-file write port
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] alu_dest,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] mem_dest,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] DataMemOut,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg
);

    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_state_e         state_q, state_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] data_mem_out_q, data_mem_out_d;

    logic              alu_accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ENT_W-1:0]  fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;

    // Ready uses the registered count only, so a pop this cycle does not free a slot until next cycle
    assign alu_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign alu_accept = alu_valid && alu_ready;
    assign head_dest  = fifo_head[ENT_W-1:DATA_W];
    assign head_data  = fifo_head[DATA_W-1:0];

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({alu_dest, alu_result}),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Commit selection: load response, then oldest buffered ALU result, then a direct ALU bypass
    always_comb begin
        state_d        = IDLE;
        reg_write_d    = 1'b0;
        mem_to_reg_d   = mem_to_reg_q;
        write_reg_d    = write_reg_q;
        result_d       = result_q;
        data_mem_out_d = data_mem_out_q;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        if (mem_valid) begin
            state_d        = WB_MEM;
            mem_to_reg_d   = 1'b1;
            data_mem_out_d = mem_data;
            write_reg_d    = mem_dest;
            reg_write_d    = (mem_dest != '0);
            fifo_push      = alu_accept && !fifo_full;
        end else if (!fifo_empty) begin
            state_d      = WB_ALU;
            mem_to_reg_d = 1'b0;
            result_d     = head_data;
            write_reg_d  = head_dest;
            reg_write_d  = (head_dest != '0);
            fifo_pop     = 1'b1;
            fifo_push    = alu_accept && !fifo_full;
        end else if (alu_accept) begin
            state_d      = WB_ALU;
            mem_to_reg_d = 1'b0;
            result_d     = alu_result;
            write_reg_d  = alu_dest;
            reg_write_d  = (alu_dest != '0);
        end
    end

    // Commit-source state and registered write-back outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            reg_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            write_reg_q    <= '0;
            result_q       <= '0;
            data_mem_out_q <= '0;
        end else begin
            state_q        <= state_d;
            reg_write_q    <= reg_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            write_reg_q    <= write_reg_d;
            result_q       <= result_d;
            data_mem_out_q <= data_mem_out_d;
        end
    end

    // MemtoReg tracks state==WB_MEM on commits and simply holds through idle cycles
    assign MemtoReg   = mem_to_reg_q;
    assign RegWrite   = reg_write_q;
    assign WriteReg   = write_reg_q;
    assign result     = result_q;
    assign DataMemOut = data_mem_out_q;

endmodule
